ysyx_25030085_ifu: RTL



---
 rtl/ysyx_25030085_ifu_pkg.sv | 21 ++
 rtl/ysyx_25030085_ifu.sv | 128 ++++++++++++
 2 files changed

// File: rtl/ysyx_25030085_ifu_pkg.sv
// Shared fetch-unit definitions: FSM encoding, error codes, NOP word, reset PC.
// No logic here; the package is imported by the IFU.
// Error codes are what the core sees on inst_err.
package ysyx_25030085_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_OUT  = 2'd3
  } ifu_state_e;

  localparam logic [1:0]  IFU_ERR_OK       = 2'b00;
  localparam logic [1:0]  IFU_ERR_MISALIGN = 2'b01;
  localparam logic [1:0]  IFU_ERR_BUS      = 2'b10;
  localparam logic [1:0]  IFU_ERR_TIMEOUT  = 2'b11;

  localparam logic [31:0] IFU_NOP          = 32'h0000_0013;
  localparam logic [31:0] IFU_RESET_PC     = 32'h8000_0000;

endpackage

// File: rtl/ysyx_25030085_ifu.sv
// Instruction fetch: one outstanding valid/ready memory request, registered inst/PC/err to the core.
// Latency: request accepted at T, response at T+1, inst_valid at T+2 (one instruction per 3 cycles best case).
// Backpressure: req held until req_ready; inst held until inst_ready; resp always taken while waiting.
module ysyx_25030085_ifu
  import ysyx_25030085_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IFU_RESET_PC,
  parameter int          TIMEOUT  = 255,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic             req_valid,
  output logic [31:0]      req_addr,
  input  logic             req_ready,
  input  logic             resp_valid,
  input  logic [31:0]      resp_data,
  input  logic             resp_err,
  output logic             inst_valid,
  output logic [31:0]      inst,
  output logic [31:0]      inst_pc,
  output logic [1:0]       inst_err,
  input  logic             inst_ready,
  input  logic [31:0]      next_pc,
  output logic [CNT_W-1:0] fetch_cnt
);

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  ifu_state_e       r_state;
  logic [31:0]      r_fetch_pc;
  logic             r_req_valid;
  logic             r_inst_valid;
  logic [31:0]      r_inst;
  logic [31:0]      r_inst_pc;
  logic [1:0]       r_inst_err;
  logic [CNT_W-1:0] r_fetch_cnt;
  logic [15:0]      r_timer;

  logic w_req_fire;
  logic w_inst_fire;
  logic w_timeout;
  logic w_next_mis;

  assign w_req_fire  = r_req_valid & req_ready;
  assign w_inst_fire = r_inst_valid & inst_ready;
  assign w_timeout   = (r_timer == TMO_LAST);
  assign w_next_mis  = (next_pc[1:0] != 2'b00);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_fetch_pc   <= RESET_PC;
      r_req_valid  <= 1'b0;
      r_inst_valid <= 1'b0;
      r_inst       <= IFU_NOP;
      r_inst_pc    <= RESET_PC;
      r_inst_err   <= IFU_ERR_OK;
      r_fetch_cnt  <= '0;
      r_timer      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_fetch_pc[1:0] != 2'b00) begin
            r_state      <= S_OUT;
            r_inst_valid <= 1'b1;
            r_inst       <= IFU_NOP;
            r_inst_pc    <= r_fetch_pc;
            r_inst_err   <= IFU_ERR_MISALIGN;
          end else begin
            r_state     <= S_REQ;
            r_req_valid <= 1'b1;
          end
        end
        S_REQ: begin
          if (w_req_fire) begin
            r_state     <= S_WAIT;
            r_req_valid <= 1'b0;
            r_timer     <= '0;
          end
        end
        S_WAIT: begin
          r_timer <= r_timer + 16'd1;
          // A response in the same cycle as the timeout still wins.
          if (resp_valid) begin
            r_state      <= S_OUT;
            r_inst_valid <= 1'b1;
            r_inst       <= resp_data;
            r_inst_pc    <= r_fetch_pc;
            r_inst_err   <= resp_err ? IFU_ERR_BUS : IFU_ERR_OK;
          end else if (w_timeout) begin
            r_state      <= S_OUT;
            r_inst_valid <= 1'b1;
            r_inst       <= IFU_NOP;
            r_inst_pc    <= r_fetch_pc;
            r_inst_err   <= IFU_ERR_TIMEOUT;
          end
        end
        S_OUT: begin
          if (w_inst_fire) begin
            r_fetch_cnt <= r_fetch_cnt + CNT_W'(1);
            r_fetch_pc  <= next_pc;
            // Misaligned targets never reach the bus; the error entry is presented directly.
            if (w_next_mis) begin
              r_inst     <= IFU_NOP;
              r_inst_pc  <= next_pc;
              r_inst_err <= IFU_ERR_MISALIGN;
            end else begin
              r_state      <= S_REQ;
              r_inst_valid <= 1'b0;
              r_req_valid  <= 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_valid  = r_req_valid;
  assign req_addr   = r_fetch_pc;
  assign inst_valid = r_inst_valid;
  assign inst       = r_inst;
  assign inst_pc    = r_inst_pc;
  assign inst_err   = r_inst_err;
  assign fetch_cnt  = r_fetch_cnt;

endmodule
